// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM arbiter and its RAM clients.
package ram_arbiter_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    // Sequencer states; the encoding is shared with the RAM and its other clients.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Request fields captured from the winning requester.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_fields_t;

    // Select the request fields belonging to the given requester id.
    function automatic req_fields_t pick_fields(
        input logic        winner,
        input req_fields_t f0,
        input req_fields_t f1
    );
        req_fields_t r_sel;
        if (winner == 1'b1) begin
            r_sel = f1;
        end else begin
            r_sel = f0;
        end
        return r_sel;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin pick: a tie goes to the requester that did not win last.
module arb_rr2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    // Decide whether anyone is requesting and which requester wins.
    always_comb begin
        valid  = req0 | req1;
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end

endmodule

// File: rtl/ram_arbiter_chk.sv
// Protocol checker for the arbiter outputs: grants and completions are one-hot, RW only while busy.
module ram_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic gnt0,
    input logic gnt1,
    input logic done0,
    input logic done1,
    input logic busy,
    input logic ram_RW
);

    a_gnt_onehot:  assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
    a_done_onehot: assert property (@(posedge clk) disable iff (rst) !(done0 && done1));
    a_rw_busy:     assert property (@(posedge clk) disable iff (rst) (ram_RW |-> busy));

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and access sequencer sharing a 16 x 32 single-port RAM between two requesters.
// Every access runs IDLE -> SETUP -> ACCESS -> HOLD so address and data bracket the single RW cycle.
module ram_arbiter
    import ram_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_dataIn,
    output logic              ram_RW,
    input  logic [DATA_W-1:0] ram_dataOut
);

    state_t              r_state;
    logic                r_last;
    logic                r_cur_id;
    req_fields_t         r_cur;
    logic                r_gnt0;
    logic                r_gnt1;
    logic                r_done0;
    logic                r_done1;
    logic                r_busy;
    logic                r_ram_rw;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_valid;
    logic                w_winner;
    req_fields_t         w_f0;
    req_fields_t         w_f1;
    req_fields_t         w_sel;

    assign w_f0  = {we0, addr0, wdata0};
    assign w_f1  = {we1, addr1, wdata1};
    assign w_sel = pick_fields(w_winner, w_f0, w_f1);

    arb_rr2 u_rr (
        .req0   (req0),
        .req1   (req1),
        .last   (r_last),
        .valid  (w_valid),
        .winner (w_winner)
    );

    // Sequencer: captures the winner in IDLE and steps the RAM through setup, strobe and hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_last   <= 1'b1;
            r_cur_id <= 1'b0;
            r_cur    <= '0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_busy   <= 1'b0;
            r_ram_rw <= 1'b0;
            r_rdata  <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done0  <= 1'b0;
                    r_done1  <= 1'b0;
                    r_ram_rw <= 1'b0;
                    if (w_valid) begin
                        r_state  <= ST_SETUP;
                        r_cur    <= w_sel;
                        r_cur_id <= w_winner;
                        r_last   <= w_winner;
                        r_gnt0   <= ~w_winner;
                        r_gnt1   <= w_winner;
                        r_busy   <= 1'b1;
                    end else begin
                        r_gnt0   <= 1'b0;
                        r_gnt1   <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    r_state  <= ST_ACCESS;
                    r_gnt0   <= 1'b0;
                    r_gnt1   <= 1'b0;
                    r_ram_rw <= r_cur.we;
                end
                ST_ACCESS: begin
                    r_state  <= ST_HOLD;
                    r_ram_rw <= 1'b0;
                    r_done0  <= ~r_cur_id;
                    r_done1  <= r_cur_id;
                    // The RAM output is stable for the whole ACCESS cycle; writes keep rdata.
                    if (!r_cur.we) begin
                        r_rdata <= ram_dataOut;
                    end
                end
                ST_HOLD: begin
                    r_state <= ST_IDLE;
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_gnt0   <= 1'b0;
                    r_gnt1   <= 1'b0;
                    r_done0  <= 1'b0;
                    r_done1  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_ram_rw <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign done0       = r_done0;
    assign done1       = r_done1;
    assign busy        = r_busy;
    assign rdata       = r_rdata;
    assign ram_RW      = r_ram_rw;
    assign ram_address = r_cur.addr;
    assign ram_dataIn  = r_cur.wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes expected transactions, a monitor checks each one.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_init;
    logic        req0, req1, we0, we1;
    logic [3:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, busy, ram_RW;
    logic [31:0] rdata, ram_dataIn, ram_dataOut;
    logic [3:0]  ram_address;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        logic        id;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [16];
    logic [31:0] model_rdata;
    bit          model_last;
    logic [31:0] ram_mem [16];

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure grant spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: write on the clock when RW is high, asynchronous read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= 32'(i + 1);
        end else if (ram_RW) begin
            ram_mem[ram_address] <= ram_dataIn;
        end
    end
    assign ram_dataOut = ram_mem[ram_address];

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .busy(busy),
        .ram_address(ram_address), .ram_dataIn(ram_dataIn), .ram_RW(ram_RW),
        .ram_dataOut(ram_dataOut)
    );

    ram_arbiter_chk chk (
        .clk(clk), .rst(rst), .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1), .busy(busy), .ram_RW(ram_RW)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    // Reference model: a transaction's effect on memory and rdata, in grant order.
    function automatic void push(input bit id, input bit we, input logic [3:0] a, input logic [31:0] d);
        exp_t e;
        if (we) model_mem[a] = d;
        else    model_rdata  = model_mem[a];
        e.id = id; e.we = we; e.addr = a; e.wdata = d; e.rdata = model_rdata;
        exp_q.push_back(e);
        model_last = id;
    endfunction

    task automatic wait_gnt(output int t, output bit id);
        int n = 0;
        t = 0; id = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!(gnt0 || gnt1) && n < 20);
        if (gnt0 || gnt1) begin
            t = cyc; id = gnt1;
        end else begin
            check("gnt_timeout", 128'd0, 128'd1);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 20);
        if (busy) check("idle_timeout", 128'(busy), 128'd0);
    endtask

    // mode 0: req0 only, 1: req1 only, 2: both together, 3: req1 rises in req0's SETUP cycle.
    task automatic issue(input int mode,
                         input bit w0, input logic [3:0] a0, input logic [31:0] d0,
                         input bit w1, input logic [3:0] a1, input logic [31:0] d1);
        int t1, t2;
        bit g;
        wait_idle();
        we0 = w0; addr0 = a0; wdata0 = d0;
        we1 = w1; addr1 = a1; wdata1 = d1;
        case (mode)
            0: begin
                push(1'b0, w0, a0, d0); req0 = 1'b1;
                wait_gnt(t1, g); req0 = 1'b0;
            end
            1: begin
                push(1'b1, w1, a1, d1); req1 = 1'b1;
                wait_gnt(t1, g); req1 = 1'b0;
            end
            2: begin
                if (model_last) begin
                    push(1'b0, w0, a0, d0); push(1'b1, w1, a1, d1);
                end else begin
                    push(1'b1, w1, a1, d1); push(1'b0, w0, a0, d0);
                end
                req0 = 1'b1; req1 = 1'b1;
                wait_gnt(t1, g);
                if (g) req1 = 1'b0; else req0 = 1'b0;
                wait_gnt(t2, g);
                req0 = 1'b0; req1 = 1'b0;
                check("tie_spacing", 128'(t2 - t1), 128'd4);
            end
            3: begin
                push(1'b0, w0, a0, d0); req0 = 1'b1;
                wait_gnt(t1, g);
                req0 = 1'b0; req1 = 1'b1;
                push(1'b1, w1, a1, d1);
                wait_gnt(t2, g);
                req1 = 1'b0;
                check("late_spacing", 128'(t2 - t1), 128'd4);
            end
            default: begin
                req0 = 1'b0; req1 = 1'b0;
            end
        endcase
    endtask

    // Monitor: on every grant pop the expected transaction and follow it through ACCESS and HOLD.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (gnt0 || gnt1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_gnt", 128'({gnt1, gnt0}), 128'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("gnt_id", 128'({gnt1, gnt0, busy}), 128'({e.id, ~e.id, 1'b1}));
                        check("setup_bus", 128'({ram_address, ram_dataIn, ram_RW, done1, done0}),
                              128'({e.addr, e.wdata, 1'b0, 2'b00}));
                        @(negedge clk);
                        check("access_bus", 128'({ram_address, ram_dataIn, ram_RW, gnt1, gnt0, done1, done0, busy}),
                              128'({e.addr, e.wdata, e.we, 4'b0000, 1'b1}));
                        @(negedge clk);
                        check("hold_bus", 128'({ram_address, ram_dataIn, ram_RW, gnt1, gnt0, busy}),
                              128'({e.addr, e.wdata, 1'b0, 2'b00, 1'b1}));
                        check("done_id", 128'({done1, done0}), 128'({e.id, ~e.id}));
                        check("rdata", 128'(rdata), 128'(e.rdata));
                    end
                end else begin
                    check("idle_quiet", 128'({ram_RW, done1, done0}), 128'd0);
                end
            end
        end
    end

    initial begin
        int  t1;
        bit  g;
        bit  rw0, rw1;
        int  m;
        logic [3:0]  ra0, ra1;
        logic [31:0] rd0, rd1;

        rst = 1'b1; mem_init = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 4'h0; addr1 = 4'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        for (int i = 0; i < 16; i++) model_mem[i] = 32'(i + 1);
        model_rdata = 32'h0;
        model_last  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; mem_init = 1'b0;
        check("reset_outputs", 128'({gnt0, gnt1, done0, done1, busy, ram_RW, ram_address, ram_dataIn, rdata}), 128'd0);

        // Write to 5 aborted by reset in its ACCESS cycle: the RAM still takes the write.
        we0 = 1'b1; addr0 = 4'h5; wdata0 = 32'hA5A5_0005; req0 = 1'b1;
        wait_gnt(t1, g);
        req0 = 1'b0;
        check("abort_gnt0", 128'({gnt1, gnt0}), 128'd1);
        @(negedge clk);
        check("abort_access_rw", 128'(ram_RW), 128'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_reset_outputs", 128'({gnt0, gnt1, done0, done1, busy, ram_RW, ram_address, ram_dataIn, rdata}), 128'd0);
        repeat (4) begin
            @(negedge clk);
            check("abort_no_done", 128'({done0, done1, busy, gnt0, gnt1}), 128'd0);
        end
        model_mem[5] = 32'hA5A5_0005;
        model_rdata  = 32'h0;
        model_last   = 1'b1;
        mon_en = 1'b1;

        issue(0, 1'b0, 4'h5, 32'h0, 1'b0, 4'h0, 32'h0);
        issue(0, 1'b1, 4'h3, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'h0);
        issue(0, 1'b0, 4'h3, 32'h0, 1'b0, 4'h0, 32'h0);
        issue(2, 1'b0, 4'h1, 32'h0, 1'b0, 4'h2, 32'h0);
        issue(2, 1'b0, 4'h4, 32'h0, 1'b0, 4'h6, 32'h0);
        issue(1, 1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'h0F0F_1234);
        issue(0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        issue(0, 1'b1, 4'h0, 32'h2, 1'b0, 4'h0, 32'h0);
        issue(3, 1'b1, 4'h7, 32'h0000_7777, 1'b0, 4'h7, 32'h0);

        for (int i = 0; i < 80; i++) begin
            m   = int'($urandom_range(3, 0));
            rw0 = 1'($urandom_range(1, 0));
            rw1 = 1'($urandom_range(1, 0));
            ra0 = 4'($urandom_range(15, 0));
            ra1 = 4'($urandom_range(15, 0));
            rd0 = $urandom();
            rd1 = $urandom();
            issue(m, rw0, ra0, rd0, rw1, ra1, rd1);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        wait_idle();
        @(negedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
